// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : clocked ALU with iterative MUL/DIV engines and a persistent flag
//           register tested by BRFL.
// Revision : 1.0
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       alu_control,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [2:0]       flag,
  output logic             branch
);

  localparam logic [2:0] c_op_addi  = 3'b000;
  localparam logic [2:0] c_op_subi  = 3'b001;
  localparam logic [2:0] c_op_typer = 3'b010;
  localparam logic [2:0] c_op_andi  = 3'b011;
  localparam logic [2:0] c_op_ori   = 3'b100;
  localparam logic [2:0] c_op_brfl  = 3'b101;
  localparam logic [2:0] c_op_cmp   = 3'b110;

  localparam logic [5:0] c_fn_add = 6'b100000;
  localparam logic [5:0] c_fn_sub = 6'b100010;
  localparam logic [5:0] c_fn_mul = 6'b000010;
  localparam logic [5:0] c_fn_div = 6'b000001;
  localparam logic [5:0] c_fn_and = 6'b100100;
  localparam logic [5:0] c_fn_or  = 6'b100101;
  localparam logic [5:0] c_fn_not = 6'b100111;

  localparam logic [2:0] c_fl_none  = 3'b000;
  localparam logic [2:0] c_fl_equal = 3'b001;
  localparam logic [2:0] c_fl_exc   = 3'b010;
  localparam logic [2:0] c_fl_ovf   = 3'b011;
  localparam logic [2:0] c_fl_unf   = 3'b100;
  localparam logic [2:0] c_fl_above = 3'b101;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic [2:0]       r_flag;
  logic             r_branch;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [2:0]       w_add_flag;
  logic [2:0]       w_sub_flag;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_res_hi;
  logic [2:0]       w_flag;
  logic             w_branch;
  logic             w_go_mul;
  logic             w_go_div;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_take;
  logic [WIDTH-1:0] w_div_diff;
  logic [WIDTH-1:0] w_eng_hi;
  logic [WIDTH-1:0] w_eng_lo;

  // Signed overflow detection from operand and result sign bits.
  always_comb begin
    w_sum = data_a + data_b;
    w_dif = data_a - data_b;
    w_add_flag = c_fl_none;
    w_sub_flag = c_fl_none;
    if (!data_a[WIDTH-1] && !data_b[WIDTH-1] && w_sum[WIDTH-1])
      w_add_flag = c_fl_ovf;
    else if (data_a[WIDTH-1] && data_b[WIDTH-1] && !w_sum[WIDTH-1])
      w_add_flag = c_fl_unf;
    if (!data_a[WIDTH-1] && data_b[WIDTH-1] && w_dif[WIDTH-1])
      w_sub_flag = c_fl_ovf;
    else if (data_a[WIDTH-1] && !data_b[WIDTH-1] && !w_dif[WIDTH-1])
      w_sub_flag = c_fl_unf;
  end

  always_comb begin
    w_res    = '0;
    w_res_hi = '0;
    w_flag   = r_flag;
    w_branch = r_branch;
    w_go_mul = 1'b0;
    w_go_div = 1'b0;
    case (alu_control)
      c_op_addi: begin w_res = w_sum; w_flag = w_add_flag; end
      c_op_subi: begin w_res = w_dif; w_flag = w_sub_flag; end
      c_op_andi: w_res = data_a & data_b;
      c_op_ori:  w_res = data_a | data_b;
      c_op_brfl: begin
        w_res    = r_result;
        w_res_hi = r_result_hi;
        w_branch = (r_flag == data_b[2:0]);
      end
      c_op_cmp: begin
        w_res    = r_result;
        w_res_hi = r_result_hi;
        if (data_a == data_b)     w_flag = c_fl_equal;
        else if (data_a > data_b) w_flag = c_fl_above;
        else                      w_flag = c_fl_none;
      end
      c_op_typer: begin
        case (func)
          c_fn_add: begin w_res = w_sum; w_flag = w_add_flag; end
          c_fn_sub: begin w_res = w_dif; w_flag = w_sub_flag; end
          c_fn_and: w_res = data_a & data_b;
          c_fn_or:  w_res = data_a | data_b;
          c_fn_not: w_res = ~data_a;
          c_fn_mul: w_go_mul = 1'b1;
          c_fn_div: begin
            if (data_b == '0) begin
              w_res    = '1;
              w_res_hi = data_a;
              w_flag   = c_fl_exc;
            end else begin
              w_go_div = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // Shared engine: {r_hi, r_lo} is the product/multiplier pair for MUL and
  // the remainder/quotient-dividend pair for DIV.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_take  = (w_div_shift >= {1'b0, r_b});
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_b;
    if (r_state == S_DIV) begin
      w_eng_hi = w_div_take ? w_div_diff : w_div_shift[WIDTH-1:0];
      w_eng_lo = {r_lo[WIDTH-2:0], w_div_take};
    end else begin
      w_eng_hi = w_mul_sum[WIDTH:1];
      w_eng_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_b         <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_valid     <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_flag      <= c_fl_none;
      r_branch    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (w_go_mul || w_go_div) begin
              r_state <= w_go_mul ? S_MUL : S_DIV;
              r_b     <= data_b;
              r_hi    <= '0;
              r_lo    <= data_a;
            end else begin
              r_result    <= w_res;
              r_result_hi <= w_res_hi;
              r_flag      <= w_flag;
              r_branch    <= w_branch;
              r_valid     <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          r_hi <= w_eng_hi;
          r_lo <= w_eng_lo;
          if (r_cnt == c_cnt_last) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_result    <= w_eng_lo;
            r_result_hi <= w_eng_hi;
            r_flag      <= (r_state == S_MUL && w_eng_hi != '0) ? c_fl_ovf : c_fl_none;
            r_valid     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign out_valid = r_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign flag      = r_flag;
  assign branch    = r_branch;

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, clocked successor to the execute-stage ALU.
- Registered operands, registered result, flag and branch outputs, plus a start/ready/out_valid handshake.
- Single-cycle ops complete in one clock. MUL and DIV run as iterative WIDTH-cycle shift-add / restoring-divide engines.
- Adds a high-word/remainder output and a persistent flag register that BRFL tests.

Parameters:
WIDTH, 32, datapath width in bits; must be ≥ 4.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  request; accepted only when ready=1.
alu_control  in  3  opcode: 000 ADDI, 001 SUBI, 010 TYPE_R, 011 ANDI, 100 ORI, 101 BRFL, 110 CMP.
func  in  6  TYPE_R function: 100000 ADD, 100010 SUB, 000010 MUL, 000001 DIV, 100100 AND, 100101 OR, 100111 NOT.
data_a  in  WIDTH  operand A.
data_b  in  WIDTH  operand B / immediate; [2:0] is the BRFL flag code.
ready  out  1  high in IDLE only.
out_valid  out  1  one-cycle pulse; result, result_hi, flag and branch are valid and held until the next completion.
result  out  WIDTH  low result word.
result_hi  out  WIDTH  MUL high word, DIV remainder; 0 for all other ops.
flag  out  3  flag register: 000 none, 001 equal, 010 exception, 011 overflow, 100 underflow, 101 above.
branch  out  1  BRFL outcome.

Behaviour:
- Reset (async assert, any state): state=IDLE, ready=1, out_valid=0, result=0, result_hi=0, flag=000, branch=0, counter=0.
- Accept: at a rising edge with start=1 and ready=1, operands, alu_control and func are captured. start while ready=0 is ignored; nothing is queued.
- FSM states: IDLE, MUL, DIV.
  - IDLE → MUL on accept with TYPE_R/MUL.
  - IDLE → DIV on accept with TYPE_R/DIV and data_b≠0.
  - MUL/DIV → IDLE when counter reaches WIDTH-1.
- Single-cycle ops (all except MUL, and DIV with data_b≠0): outputs update at the accept edge; out_valid=1 for the following cycle. Back-to-back accepts on every cycle are legal.
- MUL/DIV latency: accept at edge k; ready=0 after edge k; WIDTH iterations at edges k+1..k+WIDTH; at edge k+WIDTH the outputs load, out_valid=1 and ready=1, all in the same cycle.
- ADD/ADDI/SUB/SUBI: two's-complement, result = low WIDTH bits, result_hi=0.
  - flag=011 on positive signed overflow (operand signs imply positive, result sign 1).
  - flag=100 on negative overflow.
  - else flag=000.
- MUL: unsigned WIDTH×WIDTH product. {result_hi,result} = 2·WIDTH-bit product. flag=011 if result_hi≠0, else 000.
- DIV: unsigned. result=quotient, result_hi=remainder, flag=000.
  - data_b=0: single-cycle completion, result=all ones, result_hi=data_a, flag=010.
- AND/ANDI, OR/ORI: bitwise; NOT: bitwise ~data_a. All three leave flag unchanged.
- CMP: unsigned compare. flag=001 if equal, 101 if A>B, 000 if A<B. result and result_hi unchanged.
- BRFL: branch=1 iff flag==data_b[2:0], else 0. flag, result and result_hi unchanged. branch changes only on BRFL completions.
- Undefined opcode/func: result=0, result_hi=0, flag unchanged, out_valid still pulses.
- Reset mid-MUL/DIV: operation abandoned, no out_valid, all outputs at reset values.

Test Plan:
- Reset release, then ADDI A=0x7FFFFFFF B=1 → next cycle out_valid=1, result=0x80000000, flag=011; SUBI A=0x80000000 B=1 → result=0x7FFFFFFF, flag=100.
- MUL A=0x00010000 B=0x00010000 → ready low 32 cycles, out_valid at edge k+32, result=0, result_hi=1, flag=011; MUL 7×6 → 42, result_hi=0, flag=000.
- DIV 100/7 → latency 32, result=14, result_hi=2, flag=000; DIV 5/0 → next cycle result=0xFFFFFFFF, result_hi=5, flag=010.
- CMP 5,5 → flag=001; BRFL data_b=1 → branch=1; then CMP 3,9 → flag=000; BRFL data_b=1 → branch=0; ANDI 0xF0&0x3C → result=0x30, flag stays 000.
- Start pulsed every cycle during a MUL → ignored, exactly one out_valid. Reset asserted at iteration 10 of a DIV → immediate reset values, no out_valid, ready=1 after release.
- Back-to-back ADD, OR, NOT(0x0) on consecutive cycles → three consecutive out_valid pulses: 3, 0x0F, 0xFFFFFFFF.
